// File: rtl/watch_time_core_pkg.sv
// Shared watch definitions: field encodings, modes, limits, wrap helpers.
package watch_time_core_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam int DEF_HOUR_LIMIT = 24;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_SET    = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    POS_NONE = 3'b000,
    POS_SEC  = 3'b001,
    POS_MIN  = 3'b010,
    POS_HOUR = 3'b100
  } pos_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  // >= compare so any illegal value falls back to 0 on its next step
  function automatic logic [5:0] wrap_inc6(
    input logic [5:0] v,
    input logic [5:0] max
  );
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap_inc5(
    input logic [4:0] v,
    input logic [4:0] max
  );
    return (v >= max) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchronizer with rising-edge pulses on selected bits.
module sync_edge #(
  parameter int STAGES = 2,
  parameter int EDGE_W = 1,
  parameter int LVL_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EDGE_W-1:0] edge_in,
  input  logic [LVL_W-1:0]  lvl_in,
  output logic [EDGE_W-1:0] rise,
  output logic [LVL_W-1:0]  lvl_sync
);

  localparam int W = EDGE_W + LVL_W;

  logic [W-1:0]      chain [STAGES];
  logic [W-1:0]      last;
  logic [EDGE_W-1:0] edge_s;
  logic [EDGE_W-1:0] prev;
  logic [EDGE_W-1:0] armed;
  logic [STAGES-1:0] fill;

  assign last     = chain[STAGES-1];
  assign edge_s   = last[W-1 -: EDGE_W];
  assign lvl_sync = last[LVL_W-1:0];

  // Arm only after a real low sample, so a level high at release is no edge
  assign rise = edge_s & ~prev & armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
      prev  <= '0;
      armed <= '0;
      fill  <= '0;
    end else begin
      chain[0] <= {edge_in, lvl_in};
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
      fill <= {fill[STAGES-2:0], 1'b1};
      prev <= edge_s;
      if (fill[STAGES-1])
        armed <= armed | ~edge_s;
    end
  end

endmodule

// File: rtl/watch_time_core.sv
// Watch timekeeping core: seconds tick, field setting and blink blanking.
module watch_time_core
  import watch_time_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_LIMIT  = DEF_HOUR_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk1hz_in,
  input  logic        clk2hz_in,
  input  logic        mode_in,
  input  logic [2:0]  set_pos_in,
  input  logic        sw2,
  output logic [4:0]  hour_out,
  output logic [5:0]  min_out,
  output logic [5:0]  sec_out,
  output logic [2:0]  blank_out,
  output logic        tick_out
);

  localparam logic [4:0] HOUR_MAX = 5'(HOUR_LIMIT - 1);

  logic       tick_p;
  logic       sw2_p;
  logic       clk2hz_s;
  logic       mode_s;
  logic [2:0] pos_s;

  sync_edge #(
    .STAGES (SYNC_STAGES),
    .EDGE_W (2),
    .LVL_W  (5)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .edge_in  ({clk1hz_in, sw2}),
    .lvl_in   ({clk2hz_in, mode_in, set_pos_in}),
    .rise     ({tick_p, sw2_p}),
    .lvl_sync ({clk2hz_s, mode_s, pos_s})
  );

  mode_e mode;
  pos_e  pos;
  time_t cur;
  time_t nxt;
  logic  tick_nxt;
  logic  tick_q;
  logic [2:0] blank_q;

  assign mode = mode_e'(mode_s);
  assign pos  = pos_e'(pos_s);

  always_comb begin
    nxt      = cur;
    tick_nxt = 1'b0;
    unique case (mode)
      MODE_NORMAL: begin
        if (tick_p) begin
          tick_nxt = 1'b1;
          nxt.sec  = wrap_inc6(cur.sec, SEC_MAX);
          if (cur.sec >= SEC_MAX) begin
            nxt.min = wrap_inc6(cur.min, MIN_MAX);
            if (cur.min >= MIN_MAX)
              nxt.hour = wrap_inc5(cur.hour, HOUR_MAX);
          end
        end
      end
      MODE_SET: begin
        // Setting steps one field only; no carry between fields
        if (sw2_p) begin
          case (pos)
            POS_HOUR: nxt.hour = wrap_inc5(cur.hour, HOUR_MAX);
            POS_MIN:  nxt.min  = wrap_inc6(cur.min, MIN_MAX);
            POS_SEC:  nxt.sec  = wrap_inc6(cur.sec, SEC_MAX);
            default:  ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= '0;
      tick_q  <= 1'b0;
      blank_q <= 3'b000;
    end else begin
      cur    <= nxt;
      tick_q <= tick_nxt;
      if (mode == MODE_SET)
        blank_q <= pos_s & {3{clk2hz_s}};
      else
        blank_q <= 3'b000;
    end
  end

  assign hour_out  = cur.hour;
  assign min_out   = cur.min;
  assign sec_out   = cur.sec;
  assign blank_out = blank_q;
  assign tick_out  = tick_q;

endmodule

// File: tb/tb_watch_time_core.sv
// Randomized self-checking bench for watch_time_core against a time model.
module tb_watch_time_core;

  localparam int SS = 2;
  localparam int HL = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk1hz_in = 1'b0;
  logic       clk2hz_in = 1'b0;
  logic       mode_in = 1'b0;
  logic [2:0] set_pos_in = 3'b000;
  logic       sw2 = 1'b0;
  logic [4:0] hour_out;
  logic [5:0] min_out;
  logic [5:0] sec_out;
  logic [2:0] blank_out;
  logic       tick_out;

  int n_cmp = 0;
  int n_bad = 0;
  int mh = 0, mm = 0, ms = 0;
  int tick_cnt = 0;

  watch_time_core #(
    .SYNC_STAGES (SS),
    .HOUR_LIMIT  (HL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk1hz_in  (clk1hz_in),
    .clk2hz_in  (clk2hz_in),
    .mode_in    (mode_in),
    .set_pos_in (set_pos_in),
    .sw2        (sw2),
    .hour_out   (hour_out),
    .min_out    (min_out),
    .sec_out    (sec_out),
    .blank_out  (blank_out),
    .tick_out   (tick_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tick_out) tick_cnt++;

  function automatic logic [16:0] mt();
    return {5'(mh), 6'(mm), 6'(ms)};
  endfunction

  function automatic logic [16:0] cur();
    return {hour_out, min_out, sec_out};
  endfunction

  task automatic model_tick();
    int t;
    t  = (mh * 3600 + mm * 60 + ms + 1) % (HL * 3600);
    mh = t / 3600;
    mm = (t / 60) % 60;
    ms = t % 60;
  endtask

  task automatic model_press(input logic [2:0] p);
    case (p)
      3'b100:  mh = (mh + 1) % HL;
      3'b010:  mm = (mm + 1) % 60;
      3'b001:  ms = (ms + 1) % 60;
      default: ;
    endcase
  endtask

  task automatic settle();
    repeat (SS + 2) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk) mode_in = m;
    settle();
  endtask

  task automatic set_pos(input logic [2:0] p);
    @(negedge clk) set_pos_in = p;
    settle();
  endtask

  task automatic do_tick(
    output logic [2:0]  tk,
    output logic [16:0] t2,
    output logic [16:0] t3,
    output int          extra
  );
    @(negedge clk) clk1hz_in = 1'b1;
    @(posedge clk) #1 tk[0] = tick_out;
    @(posedge clk) #1 tk[1] = tick_out; t2 = cur();
    @(posedge clk) #1 tk[2] = tick_out; t3 = cur();
    extra = 0;
    repeat ($urandom_range(2, 5)) begin
      @(posedge clk) #1 if (tick_out) extra++;
    end
    @(negedge clk) clk1hz_in = 1'b0;
    repeat ($urandom_range(5, 8)) begin
      @(posedge clk) #1 if (tick_out) extra++;
    end
  endtask

  task automatic do_press();
    @(negedge clk) sw2 = 1'b1;
    repeat ($urandom_range(4, 6)) @(posedge clk);
    @(negedge clk) sw2 = 1'b0;
    repeat ($urandom_range(5, 7)) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({cur(), blank_out, tick_out} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", {cur(), blank_out, tick_out});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({cur(), blank_out, tick_out} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_release: got %h want 0", {cur(), blank_out, tick_out});
    end
  endtask

  task automatic test_count();
    logic [2:0]  tk;
    logic [16:0] t2, t3, prev;
    int          extra, start;
    start = tick_cnt;
    for (int i = 0; i < 5; i++) begin
      prev = mt();
      model_tick();
      do_tick(tk, t2, t3, extra);
      n_cmp++;
      if (tk !== 3'b100) begin
        n_bad++;
        $display("FAIL tick_latency[%0d]: got %b want 100", i, tk);
      end
      n_cmp++;
      if (t2 !== prev || t3 !== mt()) begin
        n_bad++;
        $display("FAIL count_step[%0d]: got %h->%h want %h->%h", i, t2, t3, prev, mt());
      end
      n_cmp++;
      if (extra != 0) begin
        n_bad++;
        $display("FAIL tick_extra[%0d]: got %0d want 0", i, extra);
      end
    end
    n_cmp++;
    if (sec_out !== 6'd5 || tick_cnt - start != 5) begin
      n_bad++;
      $display("FAIL count_five: sec %0d ticks %0d want 5 5", sec_out, tick_cnt - start);
    end
  endtask

  task automatic test_wrap();
    logic [2:0]  tk;
    logic [16:0] t2, t3, prev;
    int          extra;
    set_mode(1'b1);
    set_pos(3'b100);
    while (mh != 23) begin model_press(3'b100); do_press(); end
    set_pos(3'b010);
    while (mm != 59) begin model_press(3'b010); do_press(); end
    set_pos(3'b001);
    while (ms != 58) begin model_press(3'b001); do_press(); end
    n_cmp++;
    if (cur() !== {5'd23, 6'd59, 6'd58}) begin
      n_bad++;
      $display("FAIL preload: got %h want %h", cur(), {5'd23, 6'd59, 6'd58});
    end
    set_mode(1'b0);
    for (int i = 0; i < 2; i++) begin
      prev = mt();
      model_tick();
      do_tick(tk, t2, t3, extra);
      n_cmp++;
      if (tk !== 3'b100 || t2 !== prev || t3 !== mt() || extra != 0) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %b %h->%h want 100 %h->%h", i, tk, t2, t3, prev, mt());
      end
    end
    n_cmp++;
    if (cur() !== 17'd0) begin
      n_bad++;
      $display("FAIL wrap_midnight: got %h want 0", cur());
    end
  endtask

  task automatic test_set_min();
    logic [2:0]  tk;
    logic [16:0] t2, t3;
    int          extra, h0;
    set_mode(1'b1);
    set_pos(3'b100);
    repeat ($urandom_range(1, 3)) begin model_press(3'b100); do_press(); end
    set_pos(3'b010);
    while (mm != 59) begin model_press(3'b010); do_press(); end
    h0 = mh;
    model_press(3'b010);
    do_press();
    n_cmp++;
    if (min_out !== 6'd0 || hour_out !== 5'(h0) || cur() !== mt()) begin
      n_bad++;
      $display("FAIL set_min_wrap: got %h want %h", cur(), mt());
    end
    for (int i = 0; i < 10; i++) begin
      do_tick(tk, t2, t3, extra);
      n_cmp++;
      if (tk !== 3'b000 || extra != 0 || t3 !== mt()) begin
        n_bad++;
        $display("FAIL frozen[%0d]: got %b %h want 000 %h", i, tk, t3, mt());
      end
    end
  endtask

  task automatic test_bad_pos();
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101;
    bad[3] = 3'b110; bad[4] = 3'b111;
    @(negedge clk) clk2hz_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_pos(bad[k]);
      repeat (3) do_press();
      n_cmp++;
      if (cur() !== mt()) begin
        n_bad++;
        $display("FAIL bad_pos[%b]: got %h want %h", bad[k], cur(), mt());
      end
      if (k == 0) begin
        n_cmp++;
        if (blank_out !== 3'b000) begin
          n_bad++;
          $display("FAIL blank_none: got %b want 000", blank_out);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic b;
    set_pos(3'b100);
    for (int k = 0; k < 6; k++) begin
      b = k[0] ? 1'b0 : 1'b1;
      @(negedge clk) clk2hz_in = b;
      settle();
      n_cmp++;
      if (blank_out !== (b ? 3'b100 : 3'b000)) begin
        n_bad++;
        $display("FAIL blink[%0d]: got %b want %b", k, blank_out, b ? 3'b100 : 3'b000);
      end
    end
    @(negedge clk) clk2hz_in = 1'b1;
    settle();
    @(negedge clk) mode_in = 1'b0;
    repeat (SS + 1) @(posedge clk);
    #1;
    n_cmp++;
    if (blank_out !== 3'b000) begin
      n_bad++;
      $display("FAIL blank_exit: got %b want 000", blank_out);
    end
    settle();
  endtask

  task automatic test_random();
    logic [2:0]  tk, p;
    logic [16:0] t2, t3, prev;
    int          extra, op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        if (mode_in) set_mode(1'b0);
        prev = mt();
        model_tick();
        do_tick(tk, t2, t3, extra);
        n_cmp++;
        if (tk !== 3'b100 || t2 !== prev || t3 !== mt() || extra != 0) begin
          n_bad++;
          $display("FAIL rnd_tick[%0d]: got %b %h want %h", i, tk, t3, mt());
        end
      end else if (op == 2) begin
        if (!mode_in) set_mode(1'b1);
        p = 3'($urandom_range(0, 7));
        set_pos(p);
        model_press(p);
        do_press();
        n_cmp++;
        if (cur() !== mt()) begin
          n_bad++;
          $display("FAIL rnd_press[%0d] pos %b: got %h want %h", i, p, cur(), mt());
        end
      end else begin
        if (!mode_in) set_mode(1'b1);
        do_tick(tk, t2, t3, extra);
        n_cmp++;
        if (tk !== 3'b000 || extra != 0 || t3 !== mt()) begin
          n_bad++;
          $display("FAIL rnd_frozen[%0d]: got %b %h want %h", i, tk, t3, mt());
        end
      end
    end
    set_mode(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [2:0]  tk;
    logic [16:0] t2, t3;
    int          extra, seen;
    model_tick();
    do_tick(tk, t2, t3, extra);
    @(negedge clk) clk1hz_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    mh = 0; mm = 0; ms = 0;
    n_cmp++;
    if ({cur(), blank_out, tick_out} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h want 0", {cur(), blank_out, tick_out});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk) #1 if (tick_out || cur() !== 17'd0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL reset_no_tick: got %0d events want 0", seen);
    end
    @(negedge clk) clk1hz_in = 1'b0;
    repeat (6) @(posedge clk);
    model_tick();
    do_tick(tk, t2, t3, extra);
    n_cmp++;
    if (tk !== 3'b100 || t3 !== 17'd1 || extra != 0) begin
      n_bad++;
      $display("FAIL reset_first_tick: got %b %h want 100 %h", tk, t3, 17'd1);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_set_min();
    test_bad_pos();
    test_blank();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
